// File: rtl/fifo_pkg.sv
// Shared types and widths for the async FIFO write-side blocks.
// DATA_WIDTH is fixed here; consumers import fifo_pkg::*.
package fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ producers, arbiter and FIFO.
// slave = arbiter side, master = producer/FIFO side.
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic                          half;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            ack;
    logic                          busy;

    modport master (
        output req, req_data, full, half,
        input  wr_en, data_in, grant, ack, busy
    );

    modport slave (
        input  req, req_data, full, half,
        output wr_en, data_in, grant, ack, busy
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: first set req bit
// searching upward from last_owner+1 with wrap-around.
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic               valid,
    output logic [IW-1:0]      owner
);
    logic [IW:0] sum;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid = |req;
        owner = '0;
        sum   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            sum = {1'b0, last_owner} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_REQ))
                sum = sum - (IW+1)'(NUM_REQ);
            if (req[sum[IW-1:0]])
                owner = sum[IW-1:0];
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port.
// FIFO_ARB_HALF_THROTTLE_EN: hold off new bursts while half=1.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 8
) (
    input  logic             clk_wr,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       last_owner_q, last_owner_d;
    logic [CW-1:0]       burst_cnt_q, burst_cnt_d;
    logic                pick_valid;
    logic [IW-1:0]       pick_owner;
    logic                start_ok;
    logic                in_burst;
    logic                owner_req;
    logic                wr_en;
    logic [NUM_REQ-1:0]  owner_oh;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

`ifdef FIFO_ARB_HALF_THROTTLE_EN
    assign start_ok = pick_valid & ~bus.half;
`else
    logic unused_half;
    assign unused_half = bus.half;
    assign start_ok    = pick_valid;
`endif

    // full is used unregistered so a registered FIFO full never overruns.
    always_comb begin
        in_burst    = (state_q == ARB_BURST);
        owner_oh    = NUM_REQ'(1) << owner_q;
        owner_req   = bus.req[owner_q];
        wr_en       = rst_n & in_burst & owner_req & ~bus.full;
        bus.wr_en   = wr_en;
        bus.ack     = wr_en ? owner_oh : '0;
        bus.grant   = in_burst ? owner_oh : '0;
        bus.busy    = in_burst;
        bus.data_in = '0;
        if (rst_n && in_burst)
            bus.data_in =
                bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (start_ok) begin
                    state_d     = ARB_BURST;
                    owner_d     = pick_owner;
                    burst_cnt_d = '0;
                end
            end
            ARB_BURST: begin
                if (!owner_req) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                end else if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == CNT_LAST) begin
                        state_d      = ARB_IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_RST;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table,
// directed corner sequences and a randomized reference model.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int N    = 4;
    localparam int BL   = 8;
    localparam int DW   = DATA_WIDTH;
    localparam int DALL = N * DW;

    logic clk_wr = 1'b0;
    logic rst_n;

    fifo_wr_arbiter_if #(.NUM_REQ(N)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .BURST_LEN (BL)
    ) dut (
        .clk_wr (clk_wr),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_wr = ~clk_wr;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner = -1 means nobody holds the port.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_words = 0;

    logic [N-1:0]  s_grant;
    logic [N-1:0]  s_ack;
    logic          s_wr;
    logic [DW-1:0] s_data;

    typedef struct {
        logic         r;
        logic [N-1:0] rq;
        logic         f;
        logic [N-1:0] g;
        logic         w;
        logic [N-1:0] a;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic r,
                         input logic [N-1:0] rq,
                         input logic f,
                         input logic h,
                         input logic [DALL-1:0] d);
        logic [N-1:0]  e_g;
        logic [N-1:0]  e_a;
        logic          e_w;
        logic [DW-1:0] e_d;
        logic          hold;
        rst_n        = r;
        bus.req      = rq;
        bus.full     = f;
        bus.half     = h;
        bus.req_data = d;
        @(negedge clk_wr);
        s_grant = bus.grant;
        s_ack   = bus.ack;
        s_wr    = bus.wr_en;
        s_data  = bus.data_in;
        e_g = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e_w = r && (m_owner >= 0) && !f
              && (((rq >> m_owner) & N'(1)) != 0);
        e_a = e_w ? e_g : '0;
        e_d = '0;
        if (r && m_owner >= 0)
            e_d = DW'(d >> (m_owner * DW));
        chk("m_grant", 32'(bus.grant), 32'(e_g));
        chk("m_busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("m_wr_en", 32'(bus.wr_en), 32'(e_w));
        chk("m_ack", 32'(bus.ack), 32'(e_a));
        chk("m_data", 32'(bus.data_in), 32'(e_d));
        @(posedge clk_wr);
`ifdef FIFO_ARB_HALF_THROTTLE_EN
        hold = h;
`else
        hold = 1'b0;
`endif
        if (!r) begin
            m_owner = -1;
            m_last  = N - 1;
            m_words = 0;
        end else if (m_owner < 0) begin
            if (rq != 0 && !hold) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 &&
                        (((rq >> ((m_last + k) % N)) & N'(1)) != 0))
                        m_owner = (m_last + k) % N;
                end
                m_words = 0;
            end
        end else if (((rq >> m_owner) & N'(1)) == 0) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (e_w) begin
            m_words++;
            if (m_words == BL) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        #1;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int k = 0; k < N; k++)
            if (v[k]) r = k;
        return r;
    endfunction

    initial begin
        logic [DALL-1:0] fixd;
        int              owners[$];
        int              acks[$];
        int              gaps;
        logic [N-1:0]    prev_g;
        int              w;
        int              stalls;
        int              bcyc;
        logic            f;
        logic [DALL-1:0] d;

        fixd = 32'hDDCC_BBAA;
        tbl[0]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[3]  = '{1'b1, 4'hF, 1'b0, 4'h1, 1'b1, 4'h1};
        tbl[4]  = '{1'b0, 4'hF, 1'b0, 4'h1, 1'b0, 4'h0};
        tbl[5]  = '{1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[6]  = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 4'h4};
        tbl[7]  = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 4'h4};
        tbl[8]  = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 4'h4};
        tbl[9]  = '{1'b1, 4'h0, 1'b0, 4'h4, 1'b0, 4'h0};
        tbl[10] = '{1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[11] = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 4'h4};
        tbl[12] = '{1'b1, 4'h4, 1'b1, 4'h4, 1'b0, 4'h0};
        tbl[13] = '{1'b1, 4'h1, 1'b0, 4'h4, 1'b0, 4'h0};
        tbl[14] = '{1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[15] = '{1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 4'h1};

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].rq, tbl[i].f, 1'b0, fixd);
            chk($sformatf("t%0d_grant", i), 32'(s_grant), 32'(tbl[i].g));
            chk($sformatf("t%0d_wr_en", i), 32'(s_wr), 32'(tbl[i].w));
            chk($sformatf("t%0d_ack", i), 32'(s_ack), 32'(tbl[i].a));
        end

        // Rotation: all four requesting, five bursts.
        cycle(1'b0, 4'hF, 1'b0, 1'b0, fixd);
        prev_g = '0;
        gaps   = 0;
        for (int c = 0; c < 45; c++) begin
            cycle(1'b1, 4'hF, 1'b0, 1'b0, DALL'($urandom));
            if (s_grant != 0 && prev_g == 0) begin
                owners.push_back(oh_idx(s_grant));
                acks.push_back(0);
            end
            if (s_ack != 0 && acks.size() > 0)
                acks[acks.size()-1]++;
            if (s_grant == 0 && owners.size() > 0)
                gaps++;
            prev_g = s_grant;
        end
        chk("rr_bursts", 32'(owners.size()), 32'd5);
        for (int k = 0; k < owners.size() && k < 5; k++) begin
            chk($sformatf("rr_owner%0d", k), 32'(owners[k]), 32'(k % N));
            chk($sformatf("rr_acks%0d", k), 32'(acks[k]), 32'(BL));
        end
        chk("rr_gaps", 32'(gaps), 32'd4);

        // Full stall after word 4, five cycles.
        cycle(1'b0, 4'h0, 1'b0, 1'b0, '0);
        w      = 0;
        stalls = 0;
        bcyc   = 0;
        for (int c = 0; c < 40 && w < BL; c++) begin
            f = (w == 4 && stalls < 5);
            if (f) stalls++;
            d = '0;
            d[DW-1:0] = DW'(8'h40 + w);
            cycle(1'b1, 4'h1, f, 1'b0, d);
            if (s_grant != 0) bcyc++;
            if (f) chk("stall_wr", 32'(s_wr), 32'd0);
            if (s_wr)
                chk("stall_data", 32'(s_data), 32'(8'h40 + w));
            if (s_ack[0]) w++;
        end
        chk("stall_words", 32'(w), 32'(BL));
        chk("stall_cycles", 32'(bcyc), 32'(BL + 5));
        cycle(1'b1, 4'h1, 1'b0, 1'b0, d);
        chk("stall_idle", 32'(s_grant), 32'd0);

`ifdef FIFO_ARB_HALF_THROTTLE_EN
        cycle(1'b0, 4'h0, 1'b0, 1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 4'h2, 1'b0, 1'b1, fixd);
            chk("half_hold", 32'(s_grant), 32'd0);
        end
        cycle(1'b1, 4'h2, 1'b0, 1'b0, fixd);
        chk("half_rel0", 32'(s_grant), 32'd0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, fixd);
        chk("half_rel1", 32'(s_grant), 32'h2);
`endif

        cycle(1'b0, 4'h0, 1'b0, 1'b0, '0);
        for (int c = 0; c < 3000; c++) begin
            cycle($urandom_range(0, 99) != 0,
                  N'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  DALL'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
